non_restoring_divider_32_bit: RTL and testbench
===============================================

# non_restoring_divider_32_bit

Sequential signed 32-bit divider: the inverse of the datapath's Booth multiplier, serving the CPU's DIV instruction. It accepts a dividend and divisor on a start pulse and runs a non-restoring shift/add-subtract iteration, one quotient bit per clock. It returns the quotient (LO) and remainder (HI) with a one-cycle done pulse. It sits beside the multiplier in the ALU, and the control unit stalls on busy.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clock  in  1  rising-edge clock.
- clear_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend (Q).
- divisor  in  WIDTH  signed divisor (M).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results valid and updated.
- quotient  out  WIDTH  signed quotient (to LO).
- remainder  out  WIDTH  signed remainder (to HI).
- div_by_zero  out  1  set with done when divisor was 0.

## Operation
- Semantics:
  - Truncating signed division, so quotient rounds toward zero.
  - The remainder takes the sign of the dividend.
  - dividend = quotient*divisor + remainder, computed mod 2^WIDTH.
- Method:
  - Take magnitudes of both operands.
  - Run a WIDTH-step non-restoring divide on a WIDTH+1-bit signed partial remainder A and a WIDTH-bit register Q.
  - Each step: shift {A,Q} left 1. If A ≥ 0 then A -= |M|, otherwise A += |M|. Set Q[0] = ~A[WIDTH].
  - Final correction: if A < 0 then A += |M|.
  - Sign fix: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
- FSM states IDLE, ITER, FIX:
  - IDLE → ITER on start with divisor ≠ 0. Load magnitudes, A=0, count=0, and latch the two sign bits.
  - IDLE → IDLE on start with divisor == 0. Register quotient=all-ones, remainder=dividend, div_by_zero=1, done=1.
  - ITER runs one step per cycle. It goes to FIX after step WIDTH, at count==WIDTH-1.
  - FIX applies the restore and sign fix, registers the outputs, pulses done, then returns to IDLE.
- Overflow case: −2^31 / −1 gives quotient 0x80000000 (wraps) and remainder 0. No flag is raised.
- Ignored inputs:
  - start while busy is ignored.
  - Operands are only sampled on the accepting edge; later changes have no effect.
- Output hold: quotient, remainder and div_by_zero hold their values until the next done. div_by_zero is cleared on the next non-zero-divisor done.

## Timing
- Reset values (clear_n low at an edge): state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- Reset mid-operation aborts the operation. No done is produced and the outputs go to 0.
- Normal operation, with start accepted at edge k:
  - busy is 1 after edges k through k+32.
  - Steps occur at edges k+1 through k+32.
  - FIX happens at edge k+33: outputs update, done=1 and busy=0 for the following cycle.
  - Latency is WIDTH+2 = 34 cycles from start to done.
- Divide by zero: done=1 in the cycle after edge k, giving 1-cycle latency. busy stays 0.
- done is high for exactly one cycle.
- start high during the done cycle is accepted, since the state is IDLE. This makes back-to-back throughput one result per 34 cycles.
- busy and done are never high together.

## Structure
- Shared package (alu_pkg) holds:
  - the state encoding (IDLE/ITER/FIX)
  - DIV_WIDTH=32
  - the div-by-zero quotient constant (all-ones)
- One natural sub-module, div_addsub_33: a WIDTH+1-bit add/subtract step selected by the sign of A. It is purely combinational and reused by both the iteration and the restore.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- 100 / 7 → quotient=14, remainder=2, div_by_zero=0, done exactly 34 cycles after start, busy high cycles 1–33.
- −100 / 7 → quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). Also check 100 / −7 → −14, 2, and −100 / −7 → 14, −2.
- 100 / 0 → done one cycle after start, quotient=0xFFFFFFFF, remainder=100, div_by_zero=1, busy never high. A following 9/3 gives 3, 0 and div_by_zero=0.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Also 0xFFFFFFFF / 0x80000000 → quotient 0, remainder 0xFFFFFFFF.
- Reset mid-operation: start 100/7, drop clear_n at cycle 10 → all outputs 0 next cycle and no done. Then a restart of 50/5 gives 10, 0 at +34 cycles.
- Handshake:
  - Pulse start again at cycles 5 and 20 of an operation → ignored, single done.
  - Hold start high through the done cycle → a second operation begins, and its done arrives 34 cycles after the first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential divider.
package alu_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Quotient returned when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
  } div_state_e;

endpackage

// File: rtl/div_addsub_33.sv
// One non-restoring step: add the divisor magnitude when the partial remainder
// is negative, subtract it otherwise.
module div_addsub_33
  import alu_pkg::*;
#(
  parameter int unsigned Width = DIV_WIDTH + 1
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] m_i,
  output logic [Width-1:0] sum_o
);

  // Operation is chosen by the sign bit of the partial remainder.
  always_comb begin
    if (a_i[Width-1]) begin
      sum_o = a_i + m_i;
    end else begin
      sum_o = a_i - m_i;
    end
  end

endmodule

// File: rtl/non_restoring_divider_32_bit.sv
// Sequential signed divider: one quotient bit per clock, truncating division,
// remainder takes the dividend's sign. Results held until the next done.
module non_restoring_divider_32_bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [WIDTH:0]   a_q, a_d;        // signed partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] m_q, m_d;        // divisor magnitude
  logic [CntW-1:0]  count_q, count_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   addsub_a;
  logic [WIDTH:0]   addsub_sum;
  logic [WIDTH-1:0] rem_mag;

  // Magnitudes; -2^(WIDTH-1) maps onto itself, which is correct read unsigned.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  // The single add/sub unit sees the shifted remainder while iterating and the
  // final remainder during FIX, where its add path performs the restore.
  assign addsub_a = (state_q == StIter) ? {a_q[WIDTH-1:0], q_q[WIDTH-1]} : a_q;

  div_addsub_33 #(
    .Width (WIDTH + 1)
  ) u_addsub (
    .a_i   (addsub_a),
    .m_i   ({1'b0, m_q}),
    .sum_o (addsub_sum)
  );

  assign rem_mag = a_q[WIDTH] ? addsub_sum[WIDTH-1:0] : a_q[WIDTH-1:0];

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    count_d     = count_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = DIV_ZERO_QUOTIENT;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d   = StIter;
            a_d       = '0;
            q_d       = dividend_mag;
            m_d       = divisor_mag;
            count_d   = '0;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
          end
        end
      end
      StIter: begin
        a_d     = addsub_sum;
        q_d     = {q_q[WIDTH-2:0], ~addsub_sum[WIDTH]};
        count_d = count_q + CntW'(1);
        if (count_q == LastCount) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quotient_d  = neg_quo_q ? -q_q : q_q;
        remainder_d = neg_rem_q ? -rem_mag : rem_mag;
        dbz_d       = 1'b0;
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      count_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      count_q     <= count_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_non_restoring_divider_32_bit.sv
// Directed bench for the sequential signed divider.
module tb_non_restoring_divider_32_bit;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  non_restoring_divider_32_bit dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation; exp_lat is the number of edges after the accepting edge
  // before done is seen (33 for a normal divide, 0 for divide by zero).
  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dbz, input int exp_lat);
    int n;
    int busy_n;
    int overlap;
    @(negedge clock);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    // Operands must already be captured.
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    n = 0;
    busy_n = 0;
    overlap = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      @(negedge clock);
      n++;
    end
    if (busy && done) overlap = 1;
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy cycles"}, busy_n, exp_lat);
    check({tag, " busy&done"}, overlap, 32'd0);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    @(negedge clock);
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    int first_n;
    int idx;
    int done_n[2];
    logic [31:0] cap_q[2];
    logic [31:0] cap_r[2];

    clear_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(posedge clock);
    @(negedge clock);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dbz", {31'd0, div_by_zero}, 32'd0);
    clear_n = 1'b1;

    // Sign combinations.
    run_div("100/7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    run_div("-100/7",  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33);
    run_div("100/-7",  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33);
    run_div("-100/-7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33);

    // Divide by zero, then a normal divide clears the flag.
    run_div("100/0",   32'd100,        32'd0,          32'hFFFF_FFFF,  32'd100,        1'b1, 0);
    run_div("9/3",     32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33);

    // Extremes.
    run_div("min/-1",  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33);
    run_div("-1/min",  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0, 33);
    run_div("max/3",   32'h7FFF_FFFF,  32'd3,          32'h2AAA_AAAA,  32'd1,          1'b0, 33);

    // Reset in the middle of an operation.
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    check("abort dbz", {31'd0, div_by_zero}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clock);
    end
    check("abort no done", dones, 32'd0);
    run_div("50/5",    32'd50,         32'd5,          32'd10,         32'd0,          1'b0, 33);

    // Start pulses while busy are ignored.
    @(negedge clock);
    dividend = 32'd200;
    divisor  = 32'd9;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    dividend = 32'd1000;
    divisor  = 32'd10;
    dones    = 0;
    first_n  = -1;
    cap_q[0] = '0;
    cap_r[0] = '0;
    for (int i = 0; i < 60; i++) begin
      start = (i == 5 || i == 20) ? 1'b1 : 1'b0;
      if (done) begin
        dones++;
        if (first_n < 0) begin
          first_n  = i;
          cap_q[0] = quotient;
          cap_r[0] = remainder;
        end
      end
      @(negedge clock);
    end
    start = 1'b0;
    check("ignore done count", dones, 32'd1);
    check("ignore latency", first_n, 32'd33);
    check("ignore quotient", cap_q[0], 32'd22);
    check("ignore remainder", cap_r[0], 32'd2);

    // Start held through the done cycle starts a second operation.
    @(negedge clock);
    dividend = 32'd81;
    divisor  = 32'd9;
    start    = 1'b1;
    @(negedge clock);
    dividend = 32'd64;
    divisor  = 32'hFFFF_FFF8;
    idx = 0;
    done_n[0] = -1;
    done_n[1] = -1;
    for (int i = 0; i < 80; i++) begin
      if (i == 34) start = 1'b0;
      if (done) begin
        if (idx < 2) begin
          done_n[idx] = i;
          cap_q[idx]  = quotient;
          cap_r[idx]  = remainder;
        end
        idx++;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check("b2b done count", idx, 32'd2);
    check("b2b first latency", done_n[0], 32'd33);
    check("b2b second latency", done_n[1], 32'd67);
    check("b2b first quotient", cap_q[0], 32'd9);
    check("b2b first remainder", cap_r[0], 32'd0);
    check("b2b second quotient", cap_q[1], 32'hFFFF_FFF8);
    check("b2b second remainder", cap_r[1], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
